uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised, oversampling UART receiver. Generalises the single-format receiver to:
- configurable data width, stop-bit count and oversample rate;
- runtime parity mode;
- majority-vote sampling and false-start rejection;
- per-frame parity and framing error flags;
- a one-entry output buffer with valid/ready handshake and overrun reporting.

It sits between the board rx pin and any byte-stream consumer in the FPGA fabric.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9; sent LSB first.
STOP_BITS, 1, stop bits expected, 1 or 2.
OVERSAMPLE, 16, oversample ticks per bit, even, minimum 6.
PSCALER, 1, sysclk cycles per oversample tick, minimum 1. Baud rate = sysclk / (PSCALER*OVERSAMPLE).

Ports:
sysclk  in  1  clock.
reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
rx_i  in  1  asynchronous serial input; idles high.
parity_en  in  1  1 = a parity bit follows the data bits.
parity_odd  in  1  1 = odd parity, 0 = even parity.
rx_ready  in  1  consumer accepts the held frame.
rx_valid  out  1  held frame available.
rx_data  out  DATA_BITS  received data.
parity_err  out  1  parity mismatch on the held frame (0 when parity_en was 0).
frame_err  out  1  at least one stop bit sampled 0 on the held frame.
overrun  out  1  one-cycle pulse: a completed frame was dropped.
rx_busy  out  1  FSM is not in IDLE.

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; counters 0.
- Synchroniser flops set to 1.
- Reset asserted mid-frame aborts the frame and clears any held frame.

Input path and tick:
- rx_i passes through a 2-flop synchroniser, giving rx_s (2 cycles of latency).
- Prescaler counts 0..PSCALER-1 and asserts tick when the count equals PSCALER-1. It free-runs from reset.
- The FSM and sample counter cnt (0..OVERSAMPLE-1) advance only on tick.

Sampling:
- Within each bit, rx_s is captured at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The bit value is the majority of the three samples, decided at cnt = OVERSAMPLE/2+1.
- At cnt = OVERSAMPLE-1, cnt wraps to 0 and the FSM moves to the next bit.

FSM states and transitions:
- IDLE: on a tick with rx_s = 0, latch parity_en and parity_odd, set cnt = 0, and go to START.
  - Mode inputs that change mid-frame are ignored.
- START: if the majority decision is 1, the start is false; return to IDLE and deliver nothing. Otherwise, at the wrap go to DATA.
- DATA: shift each decided bit into the data register, LSB first. After DATA_BITS bits:
  - go to PARITY if parity is latched enabled;
  - otherwise go to STOP.
- PARITY: decide the parity bit.
  - Even parity: error when XOR(data, parity bit) = 1.
  - Odd parity: error when XOR(data, parity bit) = 0.
- STOP: decide each stop bit. Any 0 sets the frame error.
  - The frame completes at the decision point of the final stop bit (cnt = OVERSAMPLE/2+1), not at the end of the bit.
  - On completion the FSM returns immediately to IDLE for early resynchronisation.

Delivery (on the cycle after completion):
- If rx_valid = 0, or rx_valid = 1 with rx_ready = 1 in the completion cycle:
  - load rx_data, parity_err and frame_err;
  - rx_valid = 1.
- If rx_valid = 1 and rx_ready = 0:
  - drop the new frame; held outputs stay unchanged;
  - overrun = 1 for exactly one cycle.
- Handshake: the held frame is consumed on any cycle with rx_valid & rx_ready. rx_valid falls on the next cycle unless a new frame loads in the same cycle.
- While rx_valid = 1, rx_data, parity_err and frame_err are stable.
- A break (line held low) produces a frame with rx_data = 0 and frame_err = 1. The FSM then waits in IDLE and re-triggers only when rx_s goes low after having been high for at least one tick.

Test Plan:
Common setup: PSCALER=2, OVERSAMPLE=8 (16 sysclk per bit), DATA_BITS=8, STOP_BITS=1.
1. Send 0xA5 in 8N1 with rx_ready = 1 -> rx_valid pulses for 1 cycle with rx_data = 0xA5, parity_err = 0, frame_err = 0; rx_busy = 0 after the stop-bit midpoint.
2. parity_en = 1, parity_odd = 0, send 0x03 with parity bit 0 -> parity_err = 0. Repeat with parity bit 1 -> parity_err = 1. Repeat with parity_odd = 1 and parity bit 1 -> parity_err = 0.
3. Hold rx_i low for 3 sysclk, then high -> rx_busy rises then falls; rx_valid is never asserted.
4. Send 0x55 with the stop bit forced to 0 -> rx_data = 0x55, frame_err = 1. STOP_BITS=2 with the second stop bit 0 -> frame_err = 1.
5. rx_ready = 0; send 0x11, then 0x22 -> rx_data stays 0x11 and overrun pulses once. Raise rx_ready -> 0x11 is accepted and rx_valid falls. Then send 0x33 -> rx_data = 0x33.
6. Force one of the three mid-bit samples of every bit of 0x5A to the wrong level -> rx_data = 0x5A. Assert reset at data bit 4 of a frame -> all outputs 0, FSM in IDLE; the next clean 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with majority-vote bit decisions,
// false-start rejection, runtime parity, framing checks and a one-entry
// output buffer.
//
// Output handshake (valid/ready): the buffer holds one frame, made up of
// rx_data, parity_err and frame_err, and raises rx_valid while it holds it.
// The frame transfers on every cycle where rx_valid & rx_ready. While rx_valid
// is high and rx_ready is low, the payload does not change. A frame that
// completes while the buffer is still held is dropped, and overrun pulses for
// exactly one cycle.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PSCALER    = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 rx_i,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  localparam logic [PW-1:0] P_LAST  = PW'(PSCALER - 1);
  localparam logic [CW-1:0] S_LO    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] S_MID   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] S_HI    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] D_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] ST_LAST = BW'(STOP_BITS - 1);

  // Synchroniser and prescaler
  logic          sync1, sync2;
  logic          rx_s;
  logic [PW-1:0] pcnt;
  logic          tick;

  // Receive FSM and bit-level datapath
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bcnt_q;
  logic                   smp_lo, smp_mid;
  logic [DATA_BITS-1:0]   shreg;
  logic                   pen_q, podd_q;
  logic                   perr_q, ferr_q;
  logic                   armed_q;

  // Combinational decode
  logic at_dec, at_wrap, maj, start_det, done;

  assign rx_s      = sync2;
  assign tick      = (pcnt == P_LAST);
  assign rx_busy   = (state_q != IDLE);
  assign state_dbg = state_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler producing one oversample tick every PSCALER clocks.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == P_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, majority vote and completion strobe.
  always_comb begin
    maj       = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
    at_dec    = tick && (cnt_q == S_HI);
    at_wrap   = tick && (cnt_q == C_LAST);
    start_det = tick && !rx_s && armed_q;
    done      = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        // A start bit that votes high was a glitch: drop back to IDLE.
        if (at_dec && maj) state_d = IDLE;
        else if (at_wrap)  state_d = DATA;
      end
      DATA: begin
        if (at_wrap && (bcnt_q == D_LAST)) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        // Finish at the mid-bit decision so the next start edge is not missed.
        if (at_dec && (bcnt_q == ST_LAST)) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample counter, bit counter, sample capture, shift register and flags.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      smp_lo  <= 1'b0;
      smp_mid <= 1'b0;
      shreg   <= '0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q  <= '0;
      bcnt_q <= '0;
      // A start is only accepted after the line has been seen high, so a
      // held break does not re-trigger frames back to back.
      if (tick && rx_s) begin
        armed_q <= 1'b1;
      end else if (start_det) begin
        armed_q <= 1'b0;
        pen_q   <= parity_en;
        podd_q  <= parity_odd;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end
    end else if (tick) begin
      cnt_q <= at_wrap ? '0 : cnt_q + CW'(1);
      if (cnt_q == S_LO)  smp_lo  <= rx_s;
      if (cnt_q == S_MID) smp_mid <= rx_s;
      if (at_dec) begin
        if (state_q == DATA) begin
          shreg <= {maj, shreg[DATA_BITS-1:1]};
        end else if (state_q == PARITY) begin
          perr_q <= (^shreg) ^ maj ^ podd_q;
        end else if ((state_q == STOP) && !maj) begin
          ferr_q <= 1'b1;
        end
      end
      if (at_wrap && (state_q == DATA)) begin
        bcnt_q <= (bcnt_q == D_LAST) ? '0 : bcnt_q + BW'(1);
      end else if (at_wrap && (state_q == STOP)) begin
        bcnt_q <= bcnt_q + BW'(1);
      end
    end
  end

  // One-entry output buffer: load on completion, clear on consume, flag drops.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= shreg;
          parity_err <= perr_q;
          frame_err  <= ferr_q | ~maj;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: PSCALER=2, OVERSAMPLE=8 (16 clocks per bit),
// 8 data bits. A second instance uses two stop bits.
module tb_uart_rx_frame;

  localparam int DB      = 8;
  localparam int W       = DB + 2;
  localparam int BIT_CYC = 16;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic reset, rx_i, rx2, parity_en, parity_odd, rx_ready, ready2;
  logic rx_valid, parity_err, frame_err, overrun, rx_busy;
  logic [DB-1:0] rx_data;
  logic [2:0] state_dbg;
  logic v2, pe2, fe2, ov2, b2;
  logic [DB-1:0] d2;
  logic [2:0] st2;

  uart_rx_frame #(.DATA_BITS(DB), .STOP_BITS(1), .OVERSAMPLE(8), .PSCALER(2)) u_dut (
    .sysclk(sysclk), .reset(reset), .rx_i(rx_i), .parity_en(parity_en),
    .parity_odd(parity_odd), .rx_ready(rx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .rx_busy(rx_busy), .state_dbg(state_dbg)
  );

  uart_rx_frame #(.DATA_BITS(DB), .STOP_BITS(2), .OVERSAMPLE(8), .PSCALER(2)) u_dut2 (
    .sysclk(sysclk), .reset(reset), .rx_i(rx2), .parity_en(parity_en),
    .parity_odd(parity_odd), .rx_ready(ready2), .rx_valid(v2),
    .rx_data(d2), .parity_err(pe2), .frame_err(fe2),
    .overrun(ov2), .rx_busy(b2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int valid_cyc = 0;
  int ovr_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] obs2_q[$];
  logic prev_hold = 1'b0;
  logic [W-1:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: collects accepted frames, counts valid/overrun cycles and
  // checks that a held frame stays stable.
  always @(negedge sysclk) begin
    if (rx_valid) valid_cyc++;
    if (overrun) ovr_cnt++;
    if (prev_hold && rx_valid)
      chk("hold_stable", 32'({rx_data, parity_err, frame_err}), 32'(prev_word));
    if (rx_valid && rx_ready) obs_q.push_back({rx_data, parity_err, frame_err});
    if (v2 && ready2) obs2_q.push_back({d2, pe2, fe2});
    prev_hold = rx_valid && !rx_ready;
    prev_word = {rx_data, parity_err, frame_err};
  end

  // Reference: expected {data, parity_err, frame_err} from the line content.
  function automatic logic [W-1:0] model(input logic [DB-1:0] d, input bit pen,
                                         input bit pbit, input bit podd,
                                         input int nstop, input logic [1:0] stops);
    logic pe, fe;
    pe = pen ? ((^d) ^ pbit ^ podd) : 1'b0;
    fe = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) fe = 1'b1;
    return {d, pe, fe};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_i = v;
    else rx2 = v;
  endtask

  // One bit period; with gl set, the line is inverted for two clocks near
  // mid-bit, which corrupts exactly one of the three samples.
  task automatic drive_bit(input int sel, input logic b, input bit gl);
    for (int j = 0; j < BIT_CYC; j++) begin
      step();
      set_line(sel, (gl && (j == 10 || j == 11)) ? ~b : b);
    end
  endtask

  task automatic send_frame(input int sel, input logic [DB-1:0] d, input bit pen,
                            input bit pbit, input int nstop, input logic [1:0] stops,
                            input bit gl);
    drive_bit(sel, 1'b0, gl);
    for (int i = 0; i < DB; i++) drive_bit(sel, d[i], gl);
    if (pen) drive_bit(sel, pbit, gl);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i], gl);
    drive_bit(sel, 1'b1, 1'b0);
  endtask

  task automatic xfer(input int sel, input logic [DB-1:0] d, input bit pen, input bit pbit,
                      input bit podd, input int nstop, input logic [1:0] stops, input bit gl);
    parity_en = pen;
    parity_odd = podd;
    exp_q.push_back(model(d, pen, pbit, podd, nstop, stops));
    send_frame(sel, d, pen, pbit, nstop, stops, gl);
  endtask

  task automatic check_next(input int sel, input string tag);
    bit got;
    logic [W-1:0] e, o;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge sysclk);
      got = (sel == 0) ? (obs_q.size() > 0) : (obs2_q.size() > 0);
    end
    chk({tag, "_arrive"}, 32'(got), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (got) begin
      o = (sel == 0) ? obs_q.pop_front() : obs2_q.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    bit seen, gone, pen, podd, pbit, gl, sv;
    logic [DB-1:0] d, ab;

    reset = 1'b1; rx_i = 1'b1; rx2 = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    rx_ready = 1'b1; ready2 = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    chk("rst_state", 32'(state_dbg), 0);
    step();
    reset = 1'b0;
    repeat (4) step();

    // 8N1 0xA5 with consumer ready: one-cycle valid pulse.
    base = valid_cyc;
    xfer(0, 8'hA5, 0, 0, 0, 1, 2'b11, 0);
    check_next(0, "t1_a5");
    chk("t1_valid_pulse", 32'(valid_cyc - base), 1);
    chk("t1_busy_idle", 32'(rx_busy), 0);

    // Parity: even/ok, even/bad, odd/ok.
    xfer(0, 8'h03, 1, 0, 0, 1, 2'b11, 0);
    check_next(0, "t2_even_ok");
    xfer(0, 8'h03, 1, 1, 0, 1, 2'b11, 0);
    check_next(0, "t2_even_bad");
    xfer(0, 8'h03, 1, 1, 1, 1, 2'b11, 0);
    check_next(0, "t2_odd_ok");
    parity_en = 1'b0; parity_odd = 1'b0;

    // False start: 3-clock low glitch.
    base = valid_cyc;
    step(); rx_i = 1'b0;
    step(); step(); step(); rx_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin @(negedge sysclk); seen = rx_busy; end
    chk("fs_busy_rise", 32'(seen), 1);
    gone = 1'b0;
    for (int c = 0; c < 40 && !gone; c++) begin @(negedge sysclk); gone = !rx_busy; end
    chk("fs_busy_fall", 32'(gone), 1);
    chk("fs_no_valid", 32'(valid_cyc - base), 0);
    chk("fs_no_frame", 32'(obs_q.size()), 0);
    repeat (BIT_CYC) step();

    // Framing errors: single stop bit low, second of two stop bits low.
    xfer(0, 8'h55, 0, 0, 0, 1, 2'b10, 0);
    check_next(0, "t4_stop0");
    xfer(1, 8'h55, 0, 0, 0, 2, 2'b11, 0);
    check_next(1, "t4_2stop_ok");
    xfer(1, 8'h55, 0, 0, 0, 2, 2'b01, 0);
    check_next(1, "t4_2stop_bad");

    // Overrun: hold 0x11, drop 0x22, consume, then 0x33.
    rx_ready = 1'b0;
    base = ovr_cnt;
    xfer(0, 8'h11, 0, 0, 0, 1, 2'b11, 0);
    chk("t5_held_valid", 32'(rx_valid), 1);
    send_frame(0, 8'h22, 0, 0, 1, 2'b11, 0);
    chk("t5_keep_data", 32'(rx_data), 32'h11);
    chk("t5_ovr_once", 32'(ovr_cnt - base), 1);
    rx_ready = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("t5_valid_fall", 32'(rx_valid), 0);
    check_next(0, "t5_accept_11");
    xfer(0, 8'h33, 0, 0, 0, 1, 2'b11, 0);
    check_next(0, "t5_33");

    // One corrupted sample per bit.
    xfer(0, 8'h5A, 0, 0, 0, 1, 2'b11, 1);
    check_next(0, "t6_glitch_5a");

    // Reset at data bit 4 with a frame held.
    rx_ready = 1'b0;
    send_frame(0, 8'h99, 0, 0, 1, 2'b11, 0);
    chk("t6_held_pre_rst", 32'(rx_valid), 1);
    ab = 8'hB6;
    drive_bit(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(0, ab[i], 0);
    for (int j = 0; j < 8; j++) begin step(); rx_i = ab[4]; end
    chk("t6_busy_mid", 32'(rx_busy), 1);
    reset = 1'b1; rx_i = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    chk("t6_rst_valid", 32'(rx_valid), 0);
    chk("t6_rst_data", 32'(rx_data), 0);
    chk("t6_rst_perr", 32'(parity_err), 0);
    chk("t6_rst_ferr", 32'(frame_err), 0);
    chk("t6_rst_ovr", 32'(overrun), 0);
    chk("t6_rst_busy", 32'(rx_busy), 0);
    chk("t6_rst_state", 32'(state_dbg), 0);
    step();
    reset = 1'b0; rx_ready = 1'b1;
    repeat (2 * BIT_CYC) step();
    xfer(0, 8'h7E, 0, 0, 0, 1, 2'b11, 0);
    check_next(0, "t6_7e");

    // Break: line low for 14 bit times, then released.
    exp_q.push_back(model(8'h00, 0, 0, 0, 1, 2'b00));
    for (int i = 0; i < 14; i++) drive_bit(0, 1'b0, 0);
    chk("brk_busy", 32'(rx_busy), 0);
    chk("brk_state", 32'(state_dbg), 0);
    drive_bit(0, 1'b1, 0);
    drive_bit(0, 1'b1, 0);
    chk("brk_single", 32'(obs_q.size()), 1);
    check_next(0, "brk_frame");
    xfer(0, 8'hC3, 0, 0, 0, 1, 2'b11, 0);
    check_next(0, "brk_after");

    // Random frames against the reference model.
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      gl   = 1'($urandom_range(0, 1));
      sv   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      xfer(0, d, pen, pbit, podd, 1, {1'b1, sv}, gl);
      check_next(0, "rand");
      repeat ($urandom_range(0, 20)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
